// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial add/subtract controller: streams two WIDTH-bit operands LSB first
// through a single full-adder cell, carrying between cycles in a flip-flop.

module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             msb_cin_reg;
    logic             cout_reg;

    logic cell_sum;
    logic cell_cout;
    logic accept;
    logic step;
    logic last;

    full_add_cell u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign step   = (state_reg == RUN);
    assign last   = step && (cnt_reg == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = (cnt_reg == LAST_BIT) ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: the inverted operand is loaded and the
    // initial carry is seeded with sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            res_sh_reg  <= '0;
            cnt_reg     <= '0;
            carry_reg   <= 1'b0;
            msb_cin_reg <= 1'b0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
        end else if (accept) begin
            a_sh_reg   <= a;
            b_sh_reg   <= sub ? ~b : b;
            carry_reg  <= sub;
            cnt_reg    <= '0;
            res_sh_reg <= '0;
        end else if (step) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            carry_reg  <= cell_cout;
            res_sh_reg <= {cell_sum, res_sh_reg[WIDTH-1:1]};
            cnt_reg    <= cnt_reg + 1'b1;
            if (last) begin
                msb_cin_reg <= carry_reg;
                sum_reg     <= {cell_sum, res_sh_reg[WIDTH-1:1]};
                cout_reg    <= cell_cout;
            end
        end
    end

    // msb_cin and cout are captured together, so their XOR is the overflow flag
    // and holds exactly as long as the other result registers.
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = msb_cin_reg ^ cout_reg;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed bench for bit_serial_add_ctrl: WIDTH=8 scenarios plus an
// exhaustive WIDTH=4 sweep against an arithmetic reference.

module tb_bit_serial_add_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic       start4;
    logic       sub4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;
    logic       ovf4;

    int errors;
    int checks;

    bit_serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    bit_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .sub   (sub4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called right after a falling edge; the next rising edge is E0.
    // Sample j is taken at the falling edge following E(j).
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input bit scramble, input int pulse_at,
                       output int nbusy, output int done_at, output int ndone, output int both);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; done_at = -1; ndone = 0; both = 0;
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = j;
            end
            if (busy && done) both++;
            if (scramble && j < 8) begin
                a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            end
            start = (j == pulse_at);
        end
        $display("op8 a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d busy=%0d done_at=%0d",
                 ia, ib, isub, sum, cout, ovf, nbusy, done_at);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset8: got busy=%0d done=%0d sum=%h cout=%0d ovf=%0d required all 0",
                     busy, done, sum, cout, ovf);
        end
        checks++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 8'h00) begin
            errors++;
            $display("FAIL reset4: got busy=%0d done=%0d sum=%h cout=%0d ovf=%0d required all 0",
                     busy4, done4, sum4, cout4, ovf4);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int nb, da, nd, bo;
        @(negedge clk);
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, -1, nb, da, nd, bo);
        checks++;
        if (nb !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 8", nb); end
        checks++;
        if (da !== 8 || nd !== 1) begin
            errors++; $display("FAIL basic_done: got at=%0d count=%0d required at=8 count=1", da, nd);
        end
        checks++;
        if (bo !== 0) begin errors++; $display("FAIL basic_busy_done_overlap: got %0d required 0", bo); end
        checks++;
        if ({sum, cout, ovf} !== {8'h96, 1'b0, 1'b1}) begin
            errors++; $display("FAIL basic_result: got sum=%h cout=%0d ovf=%0d required 96/0/1", sum, cout, ovf);
        end
    endtask

    task automatic test_carry_borrow;
        int nb, da, nd, bo;
        @(negedge clk);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, -1, nb, da, nd, bo);
        checks++;
        if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
            errors++; $display("FAIL carry_wrap: got sum=%h cout=%0d ovf=%0d required 00/1/0", sum, cout, ovf);
        end
        op8(8'h10, 8'h20, 1'b1, 1'b0, -1, nb, da, nd, bo);
        checks++;
        if ({sum, cout, ovf} !== {8'hF0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_borrow: got sum=%h cout=%0d ovf=%0d required F0/0/0", sum, cout, ovf);
        end
    endtask

    task automatic test_sub_overflow;
        int nb, da, nd, bo;
        @(negedge clk);
        op8(8'h80, 8'h01, 1'b1, 1'b0, -1, nb, da, nd, bo);
        checks++;
        if ({sum, cout, ovf} !== {8'h7F, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sub_ovf: got sum=%h cout=%0d ovf=%0d required 7F/1/1", sum, cout, ovf);
        end
        op8(8'h80, 8'h01, 1'b1, 1'b1, -1, nb, da, nd, bo);
        checks++;
        if ({sum, cout, ovf} !== {8'h7F, 1'b1, 1'b1} || da !== 8) begin
            errors++; $display("FAIL scramble_inputs: got sum=%h cout=%0d ovf=%0d done_at=%0d required 7F/1/1 at 8",
                               sum, cout, ovf, da);
        end
    endtask

    task automatic test_back_to_back;
        int nd, bo;
        int dpos [3];
        nd = 0; bo = 0;
        dpos[0] = -1; dpos[1] = -1; dpos[2] = -1;
        @(negedge clk);
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        for (int j = 0; j < 27; j++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 3) dpos[nd] = j;
                nd++;
                $display("b2b done at E%0d sum=%h", j, sum);
                checks++;
                if (sum !== 8'h02) begin errors++; $display("FAIL b2b_sum: got %h required 02", sum); end
            end
            if (busy && done) bo++;
        end
        start = 1'b0;
        checks++;
        if (nd !== 3 || dpos[0] !== 8 || dpos[1] !== 17 || dpos[2] !== 26) begin
            errors++; $display("FAIL b2b_done_edges: got n=%0d at %0d,%0d,%0d required 3 at 8,17,26",
                               nd, dpos[0], dpos[1], dpos[2]);
        end
        checks++;
        if (bo !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d required 0", bo); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_return_idle: got busy=%0d done=%0d required 0/0", busy, done);
        end
    endtask

    task automatic test_mid_start;
        int nb, da, nd, bo;
        @(negedge clk);
        op8(8'h22, 8'h11, 1'b0, 1'b0, 3, nb, da, nd, bo);
        checks++;
        if (nd !== 1 || da !== 8 || nb !== 8 || sum !== 8'h33) begin
            errors++; $display("FAIL mid_start_ignored: got done=%0d at %0d busy=%0d sum=%h required 1 at 8, 8, 33",
                               nd, da, nb, sum);
        end
    endtask

    task automatic test_reset_mid_run;
        int nb, da, nd, bo, seen;
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            errors++; $display("FAIL async_reset: got busy=%0d done=%0d sum=%h cout=%0d ovf=%0d required all 0",
                               busy, done, sum, cout, ovf);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d active samples required 0", seen); end
        rst_n = 1'b1;
        op8(8'h03, 8'h04, 1'b0, 1'b0, -1, nb, da, nd, bo);
        checks++;
        if (da !== 8 || {sum, cout, ovf} !== {8'h07, 1'b0, 1'b0}) begin
            errors++; $display("FAIL after_reset: got done_at=%0d sum=%h cout=%0d ovf=%0d required 8, 07/0/0",
                               da, sum, cout, ovf);
        end
    endtask

    task automatic test_sweep4;
        int da, tot, sa, sb, r;
        logic [4:0] tot5;
        logic       eovf;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    a4 = 4'(x); b4 = 4'(y); sub4 = 1'(s); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    da = -1;
                    for (int j = 0; j < 6; j++) begin
                        if (j > 0) @(negedge clk);
                        if (done4 && da < 0) da = j;
                    end
                    tot  = x + ((s != 0) ? (16 - y) : y);
                    tot5 = 5'(tot);
                    sa   = (x > 7) ? x - 16 : x;
                    sb   = (y > 7) ? y - 16 : y;
                    r    = (s != 0) ? sa - sb : sa + sb;
                    eovf = (r > 7) || (r < -8);
                    $display("op4 a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d done_at=%0d",
                             a4, b4, sub4, sum4, cout4, ovf4, da);
                    checks++;
                    if ({sum4, cout4, ovf4} !== {tot5[3:0], tot5[4], eovf} || da !== 4) begin
                        errors++;
                        $display("FAIL sweep4 a=%h b=%h sub=%0d: got %h/%0d/%0d at %0d required %h/%0d/%0d at 4",
                                 a4, b4, sub4, sum4, cout4, ovf4, da, tot5[3:0], tot5[4], eovf);
                    end
                end
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_basic();
        test_carry_borrow();
        test_sub_overflow();
        test_back_to_back();
        test_mid_start();
        test_reset_mid_run();
        test_sweep4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
